// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, delayed sync/blank outputs and
// frame-buffer swap arbitration aligned to vertical blanking entry.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 800,
  parameter int H_FP       = 56,
  parameter int H_SYNC     = 120,
  parameter int H_BP       = 64,
  parameter int V_VISIBLE  = 600,
  parameter int V_FP       = 37,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 23,
  parameter bit HSYNC_POL  = 1'b1,
  parameter bit VSYNC_POL  = 1'b1,
  parameter int PIPE_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       frame_start,
  output logic       vblank,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       fb_sel
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_L  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_L  = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic [2:0] RAW_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

  typedef enum logic [1:0] {SW_IDLE, SW_ARMED, SW_ACK} swap_state_t;

  logic [10:0] h_cnt, h_next;
  logic [9:0]  v_cnt, v_next;
  logic        vis_next;
  logic        vblank_entry;
  logic [2:0]  sync_out;
  swap_state_t swap_state;

  function automatic logic [2:0] raw_of(input logic [10:0] h, input logic [9:0] v);
    logic hs_win, vs_win, vis;
    hs_win = (h >= HS_START) && (h < HS_END);
    vs_win = (v >= VS_START) && (v < VS_END);
    vis    = (h < H_VIS_L) && (v < V_VIS_L);
    return {hs_win ? HSYNC_POL : ~HSYNC_POL, vs_win ? VSYNC_POL : ~VSYNC_POL, vis};
  endfunction

  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_next = '0;
        v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_next = h_cnt + 11'd1;
      end
    end
  end

  assign vis_next     = (h_next < H_VIS_L) && (v_next < V_VIS_L);
  assign vblank_entry = pix_en && (h_next == '0) && (v_next == V_VIS_L);

  // Pixel coordinates are registered from the next counter value so they
  // always describe the counter position currently held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        h_cnt       <= h_next;
        v_cnt       <= v_next;
        pixel_x     <= vis_next ? h_next[9:0] : '0;
        pixel_y     <= vis_next ? v_next : '0;
        vblank      <= (v_next >= V_VIS_L);
        frame_start <= (h_next == '0) && (v_next == '0);
      end
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      logic [2:0] out_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_q <= RAW_IDLE;
        else if (pix_en) out_q <= raw_of(h_next, v_next);
      end
      assign sync_out = out_q;
    end else begin : g_delay
      logic [2:0] pipe [PIPE_DELAY];
      // Stage 0 captures the position being left, so stage N lags by N+1 ticks
      // relative to the counter, i.e. PIPE_DELAY relative to raw(h_cnt).
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_DELAY; i++) pipe[i] <= RAW_IDLE;
        end else if (pix_en) begin
          pipe[0] <= raw_of(h_cnt, v_cnt);
          for (int i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign sync_out = pipe[PIPE_DELAY-1];
    end
  endgenerate

  assign {hsync, vsync, active} = sync_out;

  // Swap is granted only on the edge that enters vertical blanking while the
  // request is still high; a dropped request abandons the pending swap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swap_state <= SW_IDLE;
      swap_ack   <= 1'b0;
      fb_sel     <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (swap_state)
        SW_IDLE: begin
          if (swap_req && vblank_entry) begin
            swap_state <= SW_ACK;
            swap_ack   <= 1'b1;
            fb_sel     <= ~fb_sel;
          end else if (swap_req) begin
            swap_state <= SW_ARMED;
          end
        end
        SW_ARMED: begin
          if (!swap_req) begin
            swap_state <= SW_IDLE;
          end else if (vblank_entry) begin
            swap_state <= SW_ACK;
            swap_ack   <= 1'b1;
            fb_sel     <= ~fb_sel;
          end
        end
        SW_ACK:  swap_state <= SW_IDLE;
        default: swap_state <= SW_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized scoreboard bench for vga_timing_gen using a reduced raster so
// several whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int H_VIS = 8,  H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_VIS = 6,  V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam bit HPOL = 1'b1, VPOL = 1'b0;
  localparam int DLY = 2;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  typedef struct {
    logic [9:0] px, py;
    logic hs, vs, act, fs, vb, ack, fb;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, pix_en, swap_req;
  logic [9:0] pixel_x, pixel_y;
  logic hsync, vsync, active, frame_start, vblank, swap_ack, fb_sel;

  exp_t exp_q[$];
  event pushed;
  int checks = 0, passes = 0;

  int m_p = 0;
  bit m_fb = 0, m_fs = 0, m_ack = 0;

  vga_timing_gen #(
    .H_VISIBLE(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .PIPE_DELAY(DLY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hsync(hsync), .vsync(vsync), .active(active),
    .frame_start(frame_start), .vblank(vblank),
    .swap_req(swap_req), .swap_ack(swap_ack), .fb_sel(fb_sel)
  );

  always #5 clk = ~clk;

  // Reference position is simply the number of enabled ticks since reset.
  function automatic int posH(input int p); return p % H_TOT; endfunction
  function automatic int posV(input int p); return (p / H_TOT) % V_TOT; endfunction
  function automatic int curV(); return posV(m_p); endfunction

  function automatic exp_t modelOutputs();
    exp_t e;
    int h, v, q, hq, vq;
    h = posH(m_p);
    v = posV(m_p);
    e.px  = (h < H_VIS && v < V_VIS) ? 10'(h) : 10'd0;
    e.py  = (h < H_VIS && v < V_VIS) ? 10'(v) : 10'd0;
    e.vb  = (v >= V_VIS);
    e.fs  = m_fs;
    e.ack = m_ack;
    e.fb  = m_fb;
    q = m_p - DLY;
    if (q < 0) begin
      e.hs = ~HPOL; e.vs = ~VPOL; e.act = 1'b0;
    end else begin
      hq = posH(q);
      vq = posV(q);
      e.hs  = (hq >= H_VIS + H_FP && hq < H_VIS + H_FP + H_SYNC) ? HPOL : ~HPOL;
      e.vs  = (vq >= V_VIS + V_FP && vq < V_VIS + V_FP + V_SYNC) ? VPOL : ~VPOL;
      e.act = (hq < H_VIS && vq < V_VIS);
    end
    return e;
  endfunction

  task automatic modelStep(input bit en, input bit req);
    if (!reset_n) begin
      m_p = 0; m_fb = 0; m_fs = 0; m_ack = 0;
    end else if (en) begin
      m_p++;
      m_fs  = (m_p % FRAME) == 0;
      m_ack = ((m_p % FRAME) == V_VIS * H_TOT) && req;
      if (m_ack) m_fb = !m_fb;
    end else begin
      m_fs = 0; m_ack = 0;
    end
  endtask

  task automatic applyStimulus(input bit en, input bit req);
    pix_en   = en;
    swap_req = req;
    @(posedge clk);
    #1;
    modelStep(en, req);
    exp_q.push_back(modelOutputs());
    -> pushed;
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    m_p = 0; m_fb = 0; m_fs = 0; m_ack = 0;
    #1;
    exp_q.push_back(modelOutputs());
    -> pushed;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic checkField(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d at t=%0t (model pos %0d)",
                  name, got, want, $time, m_p);
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("pixel_x",     int'(pixel_x),     int'(e.px));
    checkField("pixel_y",     int'(pixel_y),     int'(e.py));
    checkField("hsync",       int'(hsync),       int'(e.hs));
    checkField("vsync",       int'(vsync),       int'(e.vs));
    checkField("active",      int'(active),      int'(e.act));
    checkField("frame_start", int'(frame_start), int'(e.fs));
    checkField("vblank",      int'(vblank),      int'(e.vb));
    checkField("swap_ack",    int'(swap_ack),    int'(e.ack));
    checkField("fb_sel",      int'(fb_sel),      int'(e.fb));
  endtask

  // Monitor: samples a little after each expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(pushed);
      #2;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    bit req, done;
    int guard;
    reset_n  = 1'b0;
    pix_en   = 1'b0;
    swap_req = 1'b0;
    $display("[TB] start");

    doReset(3);

    // Free-running enable, no swaps.
    for (int i = 0; i < 2 * FRAME + 5; i++) applyStimulus(1'b1, 1'b0);

    // Alternating enable.
    for (int i = 0; i < 4 * FRAME; i++) applyStimulus(i % 2 == 0, 1'b0);

    // Request raised on an early line, dropped right after the ack.
    req = 0; done = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (curV() == 1 && !done) req = 1;
      applyStimulus(1'b1, req);
      if (m_ack) begin req = 0; done = 1; end
    end

    // Request withdrawn before vblank, then one held across two vblanks.
    for (int i = 0; i < 2 * FRAME; i++)
      applyStimulus(1'b1, (i < FRAME) && curV() >= 1 && curV() < 3);
    for (int i = 0; i < 2 * FRAME + 10; i++) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);

    // Reset while a swap is pending.
    guard = 0;
    while (curV() != 4 && guard < 2 * FRAME) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    swap_req = 1'b0;
    doReset(2);
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b1, 1'b0);

    // Random enable and request activity.
    req = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) req = !req;
      applyStimulus($urandom_range(0, 3) != 0, req);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 800x600@72 Hz VGA raster timing from a pixel-clock enable. Drives `pixel_x`/`pixel_y` to the frame scaler and produces sync and blanking signals delayed to line up with the scaler's registered colour output. Also arbitrates front/back frame-buffer swaps so a swap happens only at the start of vertical blanking.

## Interface
- H_VISIBLE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_VISIBLE, 600, visible lines
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, active level of hsync
- VSYNC_POL, 1, active level of vsync
- PIPE_DELAY, 2, delay in pix_en ticks applied to hsync/vsync/active; range 0..7

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous assert, active-low
- pix_en  in  1  pixel-clock enable; all counting happens only on cycles where it is high
- pixel_x  out  10  current column, 0..799 while visible, 0 in blanking
- pixel_y  out  10  current line, 0..599 while visible, 0 in blanking
- hsync  out  1  horizontal sync, delayed PIPE_DELAY ticks
- vsync  out  1  vertical sync, delayed PIPE_DELAY ticks
- active  out  1  visible-area flag, delayed PIPE_DELAY ticks; downstream forces black when low
- frame_start  out  1  one-clk pulse on the pix_en cycle where h=0, v=0 (undelayed)
- vblank  out  1  high while v_cnt >= V_VISIBLE (undelayed)
- swap_req  in  1  level request from the renderer to swap buffers
- swap_ack  out  1  one-clk pulse confirming the swap
- fb_sel  out  1  selects the front buffer the scaler reads from

## Operation
- h_cnt is 11 bits, 0..H_TOTAL-1, where H_TOTAL = 1040. v_cnt is 10 bits, 0..V_TOTAL-1, where V_TOTAL = 666.
- On each pix_en:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 with the h wrap, v_cnt wraps to 0.
- h_vis = h_cnt < H_VISIBLE; v_vis = v_cnt < V_VISIBLE.
- pixel_x = h_cnt[9:0] when h_vis && v_vis, else 0. pixel_y follows the same rule.
- Sync windows:
  - hsync is asserted for h_cnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), i.e. 856..975.
  - vsync is asserted for v_cnt in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC), i.e. 637..642.
- Raw hsync, vsync and active go through a PIPE_DELAY-deep shift register that advances only on pix_en. With PIPE_DELAY=0, the raw values are output directly.
- Swap arbitration:
  - At the pix_en where h_cnt=0 and v_cnt=V_VISIBLE (vblank entry), if swap_req=1: fb_sel toggles and swap_ack pulses for one clk.
  - At most one swap per frame.
  - The renderer must drop swap_req after swap_ack. If swap_req is still high at the next vblank entry, that is treated as a new request.
  - swap_req rising at any other time waits for the next vblank entry.
- Swap states:
  - IDLE → ARMED when swap_req=1.
  - ARMED → ACK at vblank entry.
  - ACK → IDLE after one clk.
  - If swap_req falls while ARMED, return to IDLE; no swap occurs.

## Timing
- All outputs are registered and change only on the clk edge; counters and the delay line change only on pix_en cycles.
- pixel_x/pixel_y have zero latency relative to the counters. The scaler adds 2 cycles (frame-buffer read plus colour register), hence PIPE_DELAY=2.
- swap_ack and the fb_sel toggle occur in the same clk edge as vblank rising.
- Reset values (applied asynchronously by reset_n=0):
  - h_cnt=0, v_cnt=0, pixel_x=0, pixel_y=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL, active=0.
  - Delay line cleared to these inactive values.
  - frame_start=0, vblank=0, swap_ack=0, fb_sel=0, swap FSM in IDLE.
- After reset release, the first pix_en advances h_cnt to 1. The first frame_start is at the end of the first full frame.
- Reset mid-frame: counters return to 0 immediately. A pending swap is discarded and fb_sel returns to 0.
- pix_en=0: all state holds and frame_start/swap_ack are not asserted.

## Test plan
- pix_en tied high, run 2 frames → exactly 1040*666 = 692640 clks between frame_start pulses; hsync high for 120 ticks per line starting 856+2 ticks after line start; 6 vsync lines.
- Visible corners → at (h=799, v=599) pixel_x=799, pixel_y=599; at h=800, pixel_x=0; active rises 2 ticks after h=0 on v=0 and falls 2 ticks after h=800.
- pix_en toggling 1/0 → same sequence as above with every interval doubled; outputs hold on low-enable cycles.
- swap_req raised at v=100, dropped after ack → swap_ack is a single pulse at h=0, v=600; fb_sel 0→1; no further ack in the next frame.
- swap_req pulsed at v=100 and dropped at v=200 → no swap_ack and fb_sel unchanged. swap_req held through two vblanks → two acks and fb_sel returns to 0.
- reset_n asserted at v=300 while ARMED → all outputs at reset values immediately; after release fb_sel=0 and no swap_ack occurs.
